// File: rtl/dense_layer_engine.sv
// Fixed-point fully-connected layer: buffers IN_COUNT samples, then streams
// OUT_COUNT neuron results (bias + dot product, rescale, saturate, optional ReLU).
module dense_layer_engine #(
   parameter int IN_COUNT  = 128,
   parameter int OUT_COUNT = 10,
   parameter int DATA_SIZE = 16,
   parameter int FRAC_BITS = 8,
   parameter int RELU_EN   = 1,
   localparam int ACC_SIZE = 2*DATA_SIZE + $clog2(IN_COUNT+1) + 1,
   localparam int WA_W     = (IN_COUNT*OUT_COUNT > 1) ? $clog2(IN_COUNT*OUT_COUNT) : 1,
   localparam int BA_W     = (OUT_COUNT > 1) ? $clog2(OUT_COUNT) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [DATA_SIZE-1:0] in_data,
   output logic [WA_W-1:0]      weight_adr,
   input  logic [DATA_SIZE-1:0] weight_data,
   output logic [BA_W-1:0]      bias_adr,
   input  logic [DATA_SIZE-1:0] bias_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DATA_SIZE-1:0] out_data,
   output logic [BA_W-1:0]      out_index,
   output logic                 busy,
   output logic                 done
);
   localparam int CW = $clog2(IN_COUNT+1);
   localparam int BW = (IN_COUNT > 1) ? $clog2(IN_COUNT) : 1;
   localparam logic signed [ACC_SIZE-1:0] SAT_HI =
      {{(ACC_SIZE-DATA_SIZE+1){1'b0}}, {(DATA_SIZE-1){1'b1}}};
   localparam logic signed [ACC_SIZE-1:0] SAT_LO = ~SAT_HI;

   typedef enum logic [2:0] {IDLE, LOAD, BIAS, MAC, EMIT, FIN} state_t;

   state_t                      state_q, state_d;
   logic [CW-1:0]               i_q, i_d;
   logic [BA_W-1:0]             o_q, o_d;
   logic signed [ACC_SIZE-1:0]  acc_q, acc_d;
   logic signed [DATA_SIZE-1:0] buf_q [IN_COUNT];
   logic                        buf_we;

   logic [BW-1:0]                rd_idx;
   logic signed [2*DATA_SIZE-1:0] x_ext, w_ext, prod;
   logic signed [ACC_SIZE-1:0]   shr;
   logic signed [DATA_SIZE-1:0]  res;

   // MAC step i consumes the weight addressed at step i-1 (one-cycle ROM latency)
   assign rd_idx = BW'(i_q - 1'b1);
   assign x_ext  = (2*DATA_SIZE)'(buf_q[rd_idx]);
   assign w_ext  = (2*DATA_SIZE)'($signed(weight_data));
   assign prod   = x_ext * w_ext;

   always_comb begin
      shr = acc_q >>> FRAC_BITS;
      res = shr[DATA_SIZE-1:0];
      if (shr > SAT_HI)
         res = {1'b0, {(DATA_SIZE-1){1'b1}}};
      else if (shr < SAT_LO)
         res = {1'b1, {(DATA_SIZE-1){1'b0}}};
      if (RELU_EN != 0 && res[DATA_SIZE-1])
         res = '0;
   end

   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      o_d     = o_q;
      acc_d   = acc_q;
      buf_we  = 1'b0;
      case (state_q)
         IDLE: if (start) begin
            state_d = LOAD;
            i_d     = '0;
            o_d     = '0;
         end
         LOAD: if (in_valid) begin
            buf_we = 1'b1;
            if (i_q == CW'(IN_COUNT-1)) begin
               state_d = BIAS;
               i_d     = '0;
            end else
               i_d = i_q + 1'b1;
         end
         BIAS: begin
            acc_d   = ACC_SIZE'($signed(bias_data)) <<< FRAC_BITS;
            state_d = MAC;
            i_d     = '0;
         end
         MAC: begin
            if (i_q != '0)
               acc_d = acc_q + ACC_SIZE'(prod);
            if (i_q == CW'(IN_COUNT)) begin
               state_d = EMIT;
               i_d     = '0;
            end else
               i_d = i_q + 1'b1;
         end
         EMIT: if (out_ready) begin
            if (o_q == BA_W'(OUT_COUNT-1)) begin
               state_d = FIN;
               o_d     = '0;
            end else begin
               state_d = BIAS;
               o_d     = o_q + 1'b1;
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         i_q     <= '0;
         o_q     <= '0;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         o_q     <= o_d;
         acc_q   <= acc_d;
      end
   end

   // Sample buffer survives reset and FIN; it is always rewritten before use
   always_ff @(posedge clk) begin
      if (buf_we)
         buf_q[BW'(i_q)] <= in_data;
   end

   // Bias address runs one neuron ahead in EMIT (and sits at 0 through LOAD),
   // so the address phase of BIAS overlaps the preceding cycle.
   always_comb begin
      bias_adr = o_q;
      if (state_q == EMIT)
         bias_adr = (o_q == BA_W'(OUT_COUNT-1)) ? '0 : o_q + 1'b1;
   end

   assign weight_adr = (state_q == MAC && i_q < CW'(IN_COUNT))
                     ? WA_W'(int'(i_q) * OUT_COUNT + int'(o_q)) : '0;
   assign in_ready   = (state_q == LOAD);
   assign out_valid  = (state_q == EMIT);
   assign out_data   = (state_q == EMIT) ? res : '0;
   assign out_index  = (state_q == EMIT) ? o_q : '0;
   assign busy       = (state_q != IDLE);
   assign done       = (state_q == FIN);
endmodule

// File: tb/tb_dense_layer_engine.sv
// Self-checking bench for dense_layer_engine (IN=4, OUT=3, Q8.8): table vectors,
// stall/reset sequences and randomized runs against an arithmetic reference.
module tb_dense_layer_engine;
   localparam int N = 4;
   localparam int M = 3;

   logic clk = 1'b0;
   logic rst, start, in_valid, out_ready;
   logic [15:0] in_data;
   always #5 clk = ~clk;

   logic        in_ready_r, in_ready_l, ov_r, ov_l, busy_r, busy_l, done_r, done_l;
   logic [3:0]  wa_r, wa_l;
   logic [1:0]  ba_r, ba_l, oi_r, oi_l;
   logic [15:0] wd_r, wd_l, bd_r, bd_l, od_r, od_l;

   logic [15:0] w_rom [16];
   logic [15:0] b_rom [4];

   always @(posedge clk) begin
      wd_r <= w_rom[wa_r];
      wd_l <= w_rom[wa_l];
      bd_r <= b_rom[ba_r];
      bd_l <= b_rom[ba_l];
   end

   dense_layer_engine #(.IN_COUNT(N), .OUT_COUNT(M), .DATA_SIZE(16), .FRAC_BITS(8), .RELU_EN(1)) u_relu (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready_r),
      .in_data(in_data), .weight_adr(wa_r), .weight_data(wd_r), .bias_adr(ba_r),
      .bias_data(bd_r), .out_valid(ov_r), .out_ready(out_ready), .out_data(od_r),
      .out_index(oi_r), .busy(busy_r), .done(done_r));

   dense_layer_engine #(.IN_COUNT(N), .OUT_COUNT(M), .DATA_SIZE(16), .FRAC_BITS(8), .RELU_EN(0)) u_lin (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready_l),
      .in_data(in_data), .weight_adr(wa_l), .weight_data(wd_l), .bias_adr(ba_l),
      .bias_data(bd_l), .out_valid(ov_l), .out_ready(out_ready), .out_data(od_l),
      .out_index(oi_l), .busy(busy_l), .done(done_l));

   int checks = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, " in_ready"}, {in_ready_r, in_ready_l}, 0);
      chk({tag, " out_valid"}, {ov_r, ov_l}, 0);
      chk({tag, " out_data"}, {od_r, od_l}, 0);
      chk({tag, " out_index"}, {oi_r, oi_l}, 0);
      chk({tag, " busy"}, {busy_r, busy_l}, 0);
      chk({tag, " done"}, {done_r, done_l}, 0);
      chk({tag, " weight_adr"}, {wa_r, wa_l}, 0);
      chk({tag, " bias_adr"}, {ba_r, ba_l}, 0);
   endtask

   // Reference: bias*2^8 + sum(x*w), floor-divide by 2^8, clamp, optional ReLU
   function automatic logic [15:0] model(input bit relu, input logic [3:0][15:0] x, input int o);
      longint acc, r;
      acc = longint'($signed(b_rom[o])) * 256;
      for (int i = 0; i < N; i++)
         acc += longint'($signed(x[i])) * longint'($signed(w_rom[i*M+o]));
      r = acc >>> 8;
      if (r > 32767) r = 32767;
      else if (r < -32768) r = -32768;
      if (relu && r < 0) r = 0;
      return 16'(r);
   endfunction

   // vmode/rmode: 0 always high, 1 toggle (valid only), 2 random
   task automatic run_inf(input logic [3:0][15:0] x, input int vmode, input int rmode,
                          input int stall_o, input int stall_len, input bit noise,
                          input string tag, output logic [2:0][15:0] got_r,
                          output logic [2:0][15:0] got_l, output int busy_cnt);
      int c, my_ld, load_len, o_exp, next_emit, fin_c, stall_left;
      bit v, rd, mv;
      logic [2:0][15:0] er, el;
      for (int o = 0; o < M; o++) begin
         er[o] = model(1'b1, x, o);
         el[o] = model(1'b0, x, o);
      end
      got_r = '0; got_l = '0; busy_cnt = 0;
      my_ld = 0; load_len = 0; o_exp = 0; next_emit = 0; fin_c = 0;
      stall_left = stall_len; c = 0;
      @(negedge clk);
      start = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      while (1) begin
         @(negedge clk);
         c++;
         busy_cnt += int'(busy_r);
         mv = (load_len != 0 && o_exp < M && c >= next_emit);
         chk({tag, " busy"}, {busy_r, busy_l}, (fin_c == 0 || c <= fin_c) ? 2'b11 : 2'b00);
         chk({tag, " in_ready"}, {in_ready_r, in_ready_l}, (my_ld < N) ? 2'b11 : 2'b00);
         chk({tag, " out_valid"}, {ov_r, ov_l}, mv ? 2'b11 : 2'b00);
         chk({tag, " done"}, {done_r, done_l}, (fin_c != 0 && c == fin_c) ? 2'b11 : 2'b00);
         if (mv) begin
            chk({tag, " out_data relu"}, od_r, er[o_exp]);
            chk({tag, " out_data lin"}, od_l, el[o_exp]);
            chk({tag, " out_index"}, {oi_r, oi_l}, {2'(o_exp), 2'(o_exp)});
         end
         if (fin_c != 0 && c == fin_c + 1) break;
         if (c > 400) begin
            checks++; failures++;
            $display("FAIL %s timeout: got no done within %0d cycles", tag, c);
            break;
         end
         start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
         v = (vmode == 0) ? 1'b1 : (vmode == 1) ? c[0] : 1'($urandom_range(0, 1));
         if (my_ld < N) begin
            in_valid = v;
            in_data  = x[my_ld];
            if (v) begin
               my_ld++;
               if (my_ld == N) begin
                  load_len  = c;
                  next_emit = c + N + 3;
               end
            end
         end else begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 16'($urandom());
         end
         rd = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         if (stall_left > 0 && mv && o_exp == stall_o) begin
            rd = 1'b0;
            stall_left--;
         end
         out_ready = rd;
         if (mv && rd) begin
            got_r[o_exp] = od_r;
            got_l[o_exp] = od_l;
            o_exp++;
            if (o_exp == M) fin_c = c + 1;
            else next_emit = c + N + 3;
         end
      end
      start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
   endtask

   typedef struct {
      logic [15:0]      x;
      logic [15:0]      w;
      logic [2:0][15:0] b;
      logic [2:0][15:0] er;
      logic [2:0][15:0] el;
   } vec_t;

   task automatic load_vec(input vec_t t, output logic [3:0][15:0] x);
      for (int k = 0; k < 16; k++) w_rom[k] = (k < N*M) ? t.w : 16'h0;
      for (int o = 0; o < 4; o++) b_rom[o] = (o < M) ? t.b[o] : 16'h0;
      for (int i = 0; i < N; i++) x[i] = t.x;
   endtask

   initial begin
      vec_t vt [4];
      logic [3:0][15:0] x;
      logic [2:0][15:0] gr, gl;
      int bc;

      vt[0] = '{x:16'h0100, w:16'h0080, b:{16'hFF00, 16'h0100, 16'h0000},
                er:{16'h0100, 16'h0300, 16'h0200}, el:{16'h0100, 16'h0300, 16'h0200}};
      vt[1] = '{x:16'h0100, w:16'hFF00, b:{16'h0000, 16'h0000, 16'h0000},
                er:{16'h0000, 16'h0000, 16'h0000}, el:{16'hFC00, 16'hFC00, 16'hFC00}};
      vt[2] = '{x:16'h7FFF, w:16'h7FFF, b:{16'h7FFF, 16'h7FFF, 16'h7FFF},
                er:{16'h7FFF, 16'h7FFF, 16'h7FFF}, el:{16'h7FFF, 16'h7FFF, 16'h7FFF}};
      vt[3] = '{x:16'h7FFF, w:16'h8001, b:{16'h7FFF, 16'h7FFF, 16'h7FFF},
                er:{16'h0000, 16'h0000, 16'h0000}, el:{16'h8000, 16'h8000, 16'h8000}};

      rst = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
      for (int k = 0; k < 16; k++) w_rom[k] = '0;
      for (int o = 0; o < 4; o++) b_rom[o] = '0;
      repeat (3) @(negedge clk);
      chk_idle("reset");
      rst = 1'b1;
      @(negedge clk);

      for (int t = 0; t < 4; t++) begin
         load_vec(vt[t], x);
         run_inf(x, 0, 0, -1, 0, 1'b0, $sformatf("vec%0d", t), gr, gl, bc);
         chk($sformatf("vec%0d relu results", t), 32'(gr), 32'(vt[t].er));
         chk($sformatf("vec%0d lin results", t), 32'(gl), 32'(vt[t].el));
         chk($sformatf("vec%0d total cycles", t), bc, N + M*(N+3) + 1);
      end

      // Gapped input stream and a 5-cycle output stall on neuron 1
      load_vec(vt[0], x);
      run_inf(x, 1, 0, 1, 5, 1'b0, "stall", gr, gl, bc);
      chk("stall relu results", 32'(gr), 32'(vt[0].er));
      chk("stall lin results", 32'(gl), 32'(vt[0].el));
      chk("stall total cycles", bc, 7 + M*(N+3) + 5 + 1);

      // Reset during MAC of neuron 1, with a start pulse ignored mid-inference
      @(negedge clk);
      start = 1'b1; in_valid = 1'b1; in_data = 16'h0100; out_ready = 1'b1;
      for (int c = 1; c <= 14; c++) begin
         @(negedge clk);
         start = (c == 8);
      end
      @(negedge clk);
      chk("pre-reset busy", {busy_r, busy_l}, 2'b11);
      chk("pre-reset weight_adr", wa_r, 2*M + 1);
      rst = 1'b0;
      #1;
      chk_idle("mid-mac reset");
      repeat (2) @(negedge clk);
      rst = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("post-reset no start busy", {busy_r, busy_l}, 2'b00);
         chk("post-reset no start in_ready", {in_ready_r, in_ready_l}, 2'b00);
      end
      in_valid = 1'b0; out_ready = 1'b0;
      run_inf(x, 0, 0, -1, 0, 1'b0, "after-reset", gr, gl, bc);
      chk("after-reset relu results", 32'(gr), 32'(vt[0].er));
      chk("after-reset total cycles", bc, N + M*(N+3) + 1);

      // Randomized operands, handshakes and start noise
      for (int r = 0; r < 8; r++) begin
         for (int k = 0; k < N*M; k++)
            w_rom[k] = (r < 4) ? 16'($urandom_range(0, 1023)) - 16'd512 : 16'($urandom());
         for (int o = 0; o < M; o++)
            b_rom[o] = (r < 4) ? 16'($urandom_range(0, 4095)) - 16'd2048 : 16'($urandom());
         for (int i = 0; i < N; i++)
            x[i] = (r < 4) ? 16'($urandom_range(0, 1023)) - 16'd512 : 16'($urandom());
         run_inf(x, 2, 2, -1, 0, 1'b1, $sformatf("rand%0d", r), gr, gl, bc);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
